// File: rtl/johnson_step_ctrl.sv
// Bidirectional, abortable 4-phase Johnson sequencer. A command latches direction,
// step count and rate divider, then moves the pattern one position per step period.
module johnson_step_ctrl #(
   parameter int STEP_W = 8,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              dir,
   input  logic [STEP_W-1:0] steps,
   input  logic [DIV_W-1:0]  div,
   input  logic              stop,
   output logic [3:0]        q,
   output logic [2:0]        pos,
   output logic [STEP_W-1:0] remaining,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic             dir_l;
   logic [DIV_W-1:0] div_l;
   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         q         <= 4'b0000;
         pos       <= 3'd0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         dir_l     <= 1'b0;
         div_l     <= '0;
         div_cnt   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  aborted <= 1'b0;
                  if (steps != '0) begin
                     dir_l     <= dir;
                     remaining <= steps;
                     div_l     <= div;
                     div_cnt   <= div;
                     busy      <= 1'b1;
                     state     <= RUN;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               // An abort wins over a step that falls due on the same edge.
               if (stop) begin
                  aborted <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else if (div_cnt == '0) begin
                  div_cnt   <= div_l;
                  remaining <= remaining - STEP_W'(1);
                  if (dir_l) begin
                     q   <= {q[2:0], ~q[3]};
                     pos <= pos + 3'd1;
                  end else begin
                     q   <= {~q[0], q[3:1]};
                     pos <= pos - 3'd1;
                  end
                  if (remaining == STEP_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Scoreboard bench for johnson_step_ctrl: commands push expected step events and
// completion records; an independent monitor compares them as the DUT produces them.
module tb_johnson_step_ctrl;

   localparam int STEP_W = 8;
   localparam int DIV_W  = 8;

   logic              clk   = 1'b0;
   logic              n_rst = 1'b0;
   logic              start = 1'b0;
   logic              dir   = 1'b0;
   logic              stop  = 1'b0;
   logic [STEP_W-1:0] steps = '0;
   logic [DIV_W-1:0]  div   = '0;
   logic [3:0]        q;
   logic [2:0]        pos;
   logic [STEP_W-1:0] remaining;
   logic              busy;
   logic              done;
   logic              aborted;

   typedef struct {
      int cyc;
      int pos;
   } step_t;

   typedef struct {
      int q;
      int pos;
      int rem;
      int ab;
      int cyc;
      int busy_cycles;
   } done_t;

   step_t step_q[$];
   done_t done_q[$];
   int    n_cmp     = 0;
   int    n_fail    = 0;
   int    cyc       = 0;
   int    model_pos = 0;
   int    prev_pos  = 0;
   int    busy_cnt  = 0;
   step_t mon_s;
   done_t mon_d;

   johnson_step_ctrl #(.STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .dir       (dir),
      .steps     (steps),
      .div       (div),
      .stop      (stop),
      .q         (q),
      .pos       (pos),
      .remaining (remaining),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pattern at index p: bit i is set when i < p <= i+4.
   function automatic int johnson(input int p);
      int v;
      v = 0;
      for (int i = 0; i < 4; i++)
         if (p > i && p <= i + 4) v = v | (1 << i);
      return v;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_q"}, int'(q), 0);
      checkOutput({tag, "_pos"}, int'(pos), 0);
      checkOutput({tag, "_remaining"}, int'(remaining), 0);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_done"}, int'(done), 0);
      checkOutput({tag, "_aborted"}, int'(aborted), 0);
   endtask

   // Monitor: any position change must match the next expected step; any done
   // pulse must match the next expected completion record.
   always @(negedge clk) begin
      if (!n_rst) begin
         prev_pos = 0;
         busy_cnt = 0;
      end else begin
         if (int'(pos) != prev_pos) begin
            if (step_q.size() == 0) begin
               checkOutput("unexpected_step", int'(pos), prev_pos);
            end else begin
               mon_s = step_q.pop_front();
               checkOutput("step_cycle", cyc, mon_s.cyc);
               checkOutput("step_pos", int'(pos), mon_s.pos);
               checkOutput("step_q", int'(q), johnson(mon_s.pos));
            end
         end
         if (busy) busy_cnt++;
         if (done) begin
            if (done_q.size() == 0) begin
               checkOutput("unexpected_done", int'(done), 0);
            end else begin
               mon_d = done_q.pop_front();
               checkOutput("done_cycle", cyc, mon_d.cyc);
               checkOutput("done_q", int'(q), mon_d.q);
               checkOutput("done_pos", int'(pos), mon_d.pos);
               checkOutput("done_remaining", int'(remaining), mon_d.rem);
               checkOutput("done_aborted", int'(aborted), mon_d.ab);
               checkOutput("done_busy", int'(busy), 0);
               checkOutput("busy_cycles", busy_cnt, mon_d.busy_cycles);
            end
            busy_cnt = 0;
         end
         prev_pos = int'(pos);
      end
   end

   // Issue one command; stop_at > 0 requests stop sampled stop_at edges after acceptance.
   task automatic applyStimulus(input bit d, input int n, input int dv, input int stop_at);
      int    t, e, period, full, k, rem, ab, last;
      step_t s;
      done_t r;
      @(negedge clk);
      start = 1'b1;
      dir   = d;
      steps = STEP_W'(n);
      div   = DIV_W'(dv);
      stop  = 1'b0;
      @(posedge clk);
      #1;
      t      = cyc;
      period = dv + 1;
      full   = n * period;
      e      = 0;
      if (n != 0 && stop_at > 0 && stop_at <= full) begin
         e    = t + stop_at;
         k    = (stop_at - 1) / period;
         ab   = 1;
         rem  = n - k;
         last = e;
      end else begin
         k    = n;
         ab   = 0;
         rem  = 0;
         last = t + full;
      end
      for (int j = 1; j <= k; j++) begin
         s.cyc = t + j * period;
         s.pos = (((model_pos + (d ? j : -j)) % 8) + 8) % 8;
         step_q.push_back(s);
      end
      model_pos     = (((model_pos + (d ? k : -k)) % 8) + 8) % 8;
      r.q           = johnson(model_pos);
      r.pos         = model_pos;
      r.rem         = rem;
      r.ab          = ab;
      r.cyc         = last;
      r.busy_cycles = last - t;
      done_q.push_back(r);
      start = 1'b0;
      // While running and in the done cycle, stray start/dir/steps/div and late stop must be ignored.
      for (int c = t; c <= last; c++) begin
         @(negedge clk);
         start = ($urandom_range(3) == 0);
         dir   = 1'($urandom_range(1));
         steps = STEP_W'($urandom);
         div   = DIV_W'($urandom);
         stop  = (ab == 1 && c + 1 == e) || (c == last && $urandom_range(1) == 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'($urandom_range(1));
      end
   endtask

   initial begin
      int t, n, dv, sa, full;
      step_t s;

      n_rst = 1'b0;
      #1;
      checkReset("por");
      #12;
      n_rst = 1'b1;

      applyStimulus(1'b1, 3, 0, 0);
      applyStimulus(1'b1, 5, 1, 0);
      applyStimulus(1'b0, 2, 2, 0);
      applyStimulus(1'b1, 0, 0, 0);
      applyStimulus(1'b1, 10, 1, 8);
      idle(3);
      checkOutput("aborted_held", int'(aborted), 1);
      checkOutput("remaining_held", int'(remaining), 7);
      applyStimulus(1'b0, 1, 0, 0);

      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 1, int'($urandom_range(2)), 0);

      for (int i = 0; i < 40; i++) begin
         n    = int'($urandom_range(12));
         dv   = int'($urandom_range(4));
         full = n * (dv + 1);
         sa   = (full > 0 && $urandom_range(2) == 0) ? int'($urandom_range(full, 1)) : 0;
         applyStimulus(1'($urandom_range(1)), n, dv, sa);
         if ($urandom_range(1) == 1) idle(int'($urandom_range(3)) + 1);
      end

      // Reset in the middle of a run after three full-speed steps.
      @(negedge clk);
      start = 1'b1;
      dir   = 1'b1;
      steps = STEP_W'(20);
      div   = '0;
      stop  = 1'b0;
      @(posedge clk);
      #1;
      t = cyc;
      for (int j = 1; j <= 3; j++) begin
         s.cyc = t + j;
         s.pos = (model_pos + j) % 8;
         step_q.push_back(s);
      end
      model_pos = (model_pos + 3) % 8;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("busy_mid_run", int'(busy), 1);
      #2;
      n_rst = 1'b0;
      #1;
      checkReset("midrun");
      step_q.delete();
      done_q.delete();
      model_pos = 0;
      @(negedge clk);
      #3;
      n_rst = 1'b1;

      applyStimulus(1'b0, 3, 1, 0);
      idle(2);
      checkOutput("step_q_drained", step_q.size(), 0);
      checkOutput("done_q_drained", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/johnson_step_ctrl.md
# johnson_step_ctrl

- Sequencer for a 4-phase Johnson (twisted-ring) output pattern.
- Given a start pulse, direction, step count and step-rate divider, it advances the pattern one position per step period in either direction and signals completion.
- It sits between a command source (CPU register or test FSM) and 4-phase loads such as stepper coils or multiphase enables.
- It replaces a free-running Johnson counter with a controlled, bidirectional, abortable one.

## Interface

Parameters:
- STEP_W, 8, width of step-count input and remaining-step counter
- DIV_W, 8, width of step-rate divider; step period = div+1 clk cycles

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous, active-low reset; one clock domain
- start  input  1  command strobe, sampled only in IDLE
- dir  input  1  1 = forward, 0 = reverse; latched at accepted start
- steps  input  STEP_W  number of steps to execute; latched at accepted start
- div  input  DIV_W  divider value; latched at accepted start
- stop  input  1  abort request, sampled only in RUN
- q  output  4  Johnson pattern, q[0]..q[3]
- pos  output  3  pattern index 0..7 (0 = 4'b0000)
- remaining  output  STEP_W  steps not yet executed
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse
- aborted  output  1  last command ended by stop; held until next accepted start

## Operation

- **Forward step:** q[0] <= ~q[3], q[i] <= q[i-1]; pos <= pos+1 mod 8.
- **Reverse step:** q[3] <= ~q[0], q[i] <= q[i+1]; pos <= pos-1 mod 8.
- **Sequence** {q3,q2,q1,q0} at pos 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. Wraps 7<->0 in both directions.
- **FSM:** IDLE, RUN, DONE.
  - **IDLE:**
    - start=1 and steps!=0: latch dir, steps->remaining, div->div_l and div_cnt; clear aborted; go to RUN.
    - start=1 and steps==0: clear aborted; go to DONE with no movement.
  - **RUN:**
    - stop=1: go to DONE, set aborted; no step this edge. stop has priority over a due step.
    - div_cnt==0: step q/pos, remaining--, div_cnt<=div_l. If remaining was 1, go to DONE.
    - Otherwise: div_cnt--.
  - **DONE:** done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored, including in DONE. Inputs other than stop are ignored during RUN.
- stop outside RUN is ignored.
- q/pos hold their position between commands. They are never reset by a command, only by n_rst.
- remaining holds its value after abort and reads 0 after normal completion.
- **Reset values (n_rst low, asynchronous):** q=0000, pos=0, remaining=0, busy=0, done=0, aborted=0, state=IDLE, div_cnt=0.
- **Reset mid-RUN:** immediate return to all reset values; no done pulse.

## Timing

- All outputs are registered; no combinational input-to-output paths.
- start accepted at edge T:
  - busy=1 from after T.
  - First q change at edge T+1+div.
  - Subsequent q changes every div+1 cycles.
  - Last q change at edge T+steps*(div+1).
  - done=1 and busy=0 in the cycle following that edge.
- steps==0: done=1 in the cycle after edge T; busy never asserted.
- stop sampled at edge E in RUN: busy=0 and done=1 after E, aborted=1; q unchanged at E.
- Earliest next accepted start is the edge after the done cycle. Minimum command-to-command spacing is therefore steps*(div+1)+2 edges.
- div=0 gives one step per cycle.

## Test plan

- **Reset:** assert n_rst mid-simulation with arbitrary state -> q=0000, pos=0, busy=0, done=0, aborted=0 immediately, with no clock edge required.
- **Forward, full speed:** dir=1, steps=3, div=0 from reset.
  - q = 0001, 0011, 0111 on three consecutive edges.
  - pos=3; done one cycle later; busy high exactly 3 cycles.
- **Reverse wrap with divider:** dir=0, steps=2, div=2 from pos 0.
  - q=1000 (pos 7) at edge T+3, q=1100 (pos 6) at T+6.
  - done after T+6; remaining=0.
- **Zero steps:** steps=0 -> done pulse one cycle after start, busy never 1, q unchanged, aborted=0.
- **Abort:** steps=10, div=1, stop asserted coincident with the 4th step's due edge.
  - Only 3 steps taken; remaining=7, aborted=1, one done pulse.
  - aborted clears on the next accepted start.
- **Ignored inputs:**
  - start pulses during RUN and DONE -> no change to remaining/dir, no extra command.
  - stop during IDLE -> no done pulse.
  - 16 forward single steps -> pattern returns to 0000 twice, pos wraps 7->0.
